// File: rtl/xalu_seq.sv
// rtl/xalu_seq.sv - multi-cycle slice-serial ALU with handshakes and optional accumulator (XALU_SEQ_ACC_EN)
module xalu_seq #(
    parameter int DATA_W  = 16,
    parameter int SLICE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [2:0]        in_func,
    input  logic              in_com,
    input  logic              in_ci_left,
    input  logic              in_ci_right,
    input  logic              in_acc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_d,
    output logic              out_co_left,
    output logic              out_co_right,
    output logic              out_zero,
    output logic              out_neg_zero,
    output logic              out_equ
);

    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NSLICE - 1);

    localparam logic [2:0] F_ADD = 3'd0;
    localparam logic [2:0] F_AND = 3'd1;
    localparam logic [2:0] F_OR  = 3'd2;
    localparam logic [2:0] F_XOR = 3'd3;
    localparam logic [2:0] F_PA  = 3'd4;
    localparam logic [2:0] F_PB  = 3'd5;
    localparam logic [2:0] F_SHR = 3'd6;
    localparam logic [2:0] F_SHL = 3'd7;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t              state;
    logic [DATA_W-1:0]   a_r;
    logic [DATA_W-1:0]   b_r;
    logic [2:0]          func_r;
    logic                com_r;
    logic                cil_r;
    logic                cir_r;
    logic [CNT_W-1:0]    k;
    logic                carry;
    logic [DATA_W-1:0]   res;

    logic [DATA_W-1:0]   a_eff;
    logic [DATA_W-1:0]   logic_full;
    logic [SLICE_W-1:0]  sl_a;
    logic [SLICE_W-1:0]  sl_b;
    logic [SLICE_W:0]    sum;
    logic [SLICE_W-1:0]  sl_res;
    logic [DATA_W-1:0]   next_res;
    logic                co_left_nx;
    logic                co_right_nx;

`ifdef XALU_SEQ_ACC_EN
    // Accumulate mode: previous result stands in for operand A
    assign a_eff = in_acc ? out_d : in_a;
`else
    logic unused_acc;
    assign unused_acc = in_acc;
    assign a_eff      = in_a;
`endif

    // Slice datapath: ADD ripples the registered carry, other functions slice a full-width value
    always_comb begin
        logic_full = '0;
        case (func_r)
            F_AND:   logic_full = a_r & b_r;
            F_OR:    logic_full = a_r | b_r;
            F_XOR:   logic_full = a_r ^ b_r;
            F_PA:    logic_full = a_r;
            F_PB:    logic_full = b_r;
            F_SHR:   logic_full = {cil_r, a_r[DATA_W-1:1]};
            F_SHL:   logic_full = {a_r[DATA_W-2:0], cir_r};
            default: logic_full = '0;
        endcase
        sl_a     = a_r[int'(k)*SLICE_W +: SLICE_W];
        sl_b     = b_r[int'(k)*SLICE_W +: SLICE_W];
        sum      = {1'b0, sl_a} + {1'b0, sl_b} + {{SLICE_W{1'b0}}, carry};
        sl_res   = (func_r == F_ADD) ? sum[SLICE_W-1:0] : logic_full[int'(k)*SLICE_W +: SLICE_W];
        sl_res   = sl_res ^ {SLICE_W{com_r}};
        next_res = res;
        next_res[int'(k)*SLICE_W +: SLICE_W] = sl_res;
        co_left_nx  = (func_r == F_ADD) ? sum[SLICE_W] :
                      (func_r == F_SHL) ? a_r[DATA_W-1] : 1'b0;
        co_right_nx = (func_r == F_SHR) ? a_r[0] : 1'b0;
    end

    // Control FSM with registered handshakes; outputs publish only on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            a_r          <= '0;
            b_r          <= '0;
            func_r       <= '0;
            com_r        <= 1'b0;
            cil_r        <= 1'b0;
            cir_r        <= 1'b0;
            k            <= '0;
            carry        <= 1'b0;
            res          <= '0;
            out_d        <= '0;
            out_co_left  <= 1'b0;
            out_co_right <= 1'b0;
            out_zero     <= 1'b0;
            out_neg_zero <= 1'b0;
            out_equ      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a_eff;
                        b_r      <= in_b;
                        func_r   <= in_func;
                        com_r    <= in_com;
                        cil_r    <= in_ci_left;
                        cir_r    <= in_ci_right;
                        k        <= '0;
                        carry    <= in_ci_right;
                        res      <= '0;
                        in_ready <= 1'b0;
                        state    <= EXEC;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                EXEC: begin
                    res   <= next_res;
                    carry <= sum[SLICE_W];
                    k     <= k + 1'b1;
                    if (k == LAST_K) begin
                        state        <= DONE;
                        out_valid    <= 1'b1;
                        out_d        <= next_res;
                        out_co_left  <= co_left_nx;
                        out_co_right <= co_right_nx;
                        out_zero     <= (next_res == '0);
                        out_neg_zero <= &next_res;
                        out_equ      <= (a_r == b_r);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/xalu_seq.md
# xalu_seq

Parametrised multi-cycle successor to the 4-bit ALU slice. It accepts DATA_W-bit operands through a valid/ready handshake and executes them one SLICE_W-bit slice per clock, LSB first, with carries registered between slices. It presents the full-width result and status flags through an output handshake. It keeps the 8-function set, complement-output mode and left/right carry semantics of the slice, and adds a result/accumulator register.

## Interface
Parameters:
- DATA_W, 16: operand/result width. Must be a multiple of SLICE_W.
- SLICE_W, 4: bits processed per cycle. NSLICE = DATA_W/SLICE_W, and NSLICE >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation.
- in_a, in_b  in  DATA_W  operands A, B.
- in_func  in  3  0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL.
- in_com  in  1  invert the result.
- in_ci_left, in_ci_right  in  1  left (MSB-side) and right (LSB-side) carry inputs.
- in_acc  in  1  use the accumulator as A; effective only with XALU_SEQ_ACC_EN.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_d  out  DATA_W  result; also serves as the accumulator.
- out_co_left, out_co_right  out  1  carry outputs.
- out_zero, out_neg_zero, out_equ  out  1  status flags.

## Operation
- States: IDLE, EXEC, DONE.
- **IDLE:**
  - in_ready = 1.
  - On in_valid & in_ready, latch A, B, func, com, ci_left, ci_right. Clear the slice counter, set the carry register to ci_right, and go to EXEC.
- **EXEC:**
  - Each cycle computes slice k = bits [k*SLICE_W +: SLICE_W] into the result register and increments k.
  - ADD ripples the registered carry into the slice; carry out of the slice is registered for slice k+1.
  - After slice NSLICE-1, go to DONE.
- **DONE:**
  - out_valid = 1.
  - On out_ready, go to IDLE.
- Result functions, over the full width:
  - ADD: A+B+ci_right.
  - AND, OR, XOR: bitwise on A, B.
  - PASSA: A. PASSB: B.
  - SHR: {ci_left, A[DATA_W-1:1]}.
  - SHL: {A[DATA_W-2:0], ci_right}.
  - Slices fetch neighbouring bits from the latched full-width A, so shift results never depend on slice order.
- Complement: when com=1, every result bit is inverted before it is stored.
- Carry outputs (not affected by com):
  - out_co_left = carry out of bit DATA_W-1 for ADD; A[DATA_W-1] for SHL; 0 for all other functions.
  - out_co_right = A[0] for SHR; else 0.
- Flags are computed on the final stored result:
  - out_zero = all bits 0.
  - out_neg_zero = all bits 1.
  - out_equ = (A == B) over the full width, using the effective A.
- out_d, the carry outputs and the flags are registered. They are updated when entering DONE and hold until the next operation's DONE.
- Inputs presented outside IDLE are ignored.

## Timing
- On reset assertion, asynchronously:
  - state = IDLE; slice counter and carry register = 0.
  - out_d = 0; all flags and carries = 0; out_valid = 0; in_ready = 0.
- in_ready is registered. It rises on the first clock edge after rst_n deasserts.
- Latency: the accept edge is E0; out_valid rises after edge E_NSLICE, i.e. NSLICE cycles after acceptance.
- Throughput: one operation per NSLICE+2 cycles when out_ready is held high. in_ready is 0 throughout EXEC and DONE.
- The DONE→IDLE edge deasserts out_valid and asserts in_ready. New inputs are sampled no earlier than the following edge.
- Backpressure: while out_ready = 0 in DONE, out_valid and all outputs hold indefinitely.
- Reset mid-EXEC or mid-DONE aborts the operation and discards it. No partial result becomes visible.
- With NSLICE = 1, EXEC lasts exactly one cycle.

## Configuration
- XALU_SEQ_ACC_EN defined:
  - An accept with in_acc = 1 latches out_d (the previous result, 0 after reset) as A instead of in_a.
  - out_equ compares that value with B.
- XALU_SEQ_ACC_EN undefined: in_acc is ignored and A is always in_a.

## Test plan
All scenarios use DATA_W = 16, SLICE_W = 4.
- ADD A=0xFFFF, B=0x0001, ci_right=0, com=0 -> out_d=0x0000, co_left=1, zero=1, equ=0; out_valid exactly 4 cycles after the accept edge.
- SHR A=0x8001, ci_left=1 -> 0xC000, co_right=1, co_left=0. SHL A=0x8001, ci_right=0 -> 0x0002, co_left=1.
- XOR A=B=0x1234, com=1 -> out_d=0xFFFF, neg_zero=1, zero=0, equ=1, co_left=0.
- Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid -> out_valid and out_d stable, in_ready=0, no new operation accepted; release -> IDLE on the next edge.
- Assert rst_n=0 during EXEC slice 2 of ADD 0x1111+0x2222 -> all outputs 0 immediately. After release, ADD 0x0005+0x0003 -> 0x0008.
- ADD 0x0003+0x0004 -> 0x0007, then ADD with in_acc=1, in_a=0x1000, B=0x0001 -> 0x0008 with the macro, 0x1001 without.
